// File: rtl/pll_seq_pkg.sv
// Shared state encoding, counter sizing and saturation limits for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } pll_seq_state_t;

    localparam logic [3:0] RETRY_CNT_MAX = 4'hF;
    localparam logic [7:0] LOST_CNT_MAX  = 8'hFF;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles. Backpressure: none, free-running.
// Reset clears both flops so the output reads low until real samples arrive.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulse pll_rst, filter lock, hold sys_rst, then release to RUN.
// Latency: pll_locked change reaches the state 3 refclk cycles later (2 sync + 1).
// Backpressure: none; sw_rst_req is a single-cycle request and is never stalled.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILT      = 1024,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int HOLD_CYCLES    = 256
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_lost_cnt,
    output logic [3:0] retry_cnt
);

    localparam int RST_W  = cnt_w(PLL_RST_CYCLES);
    localparam int FILT_W = cnt_w(LOCK_FILT);
    localparam int TOUT_W = cnt_w(LOCK_TIMEOUT);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(LOCK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic           locked_s;
    pll_seq_state_t state;
    pll_seq_state_t nxt;
    logic           loss_evt;
    logic           tout_evt;
    logic           restart;

    logic [RST_W-1:0]  rst_cnt;
    logic [FILT_W-1:0] filt_cnt;
    logic [TOUT_W-1:0] tout_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // sw_rst_req outranks lock loss, so a coincident loss is not counted.
    always_comb begin
        nxt      = state;
        loss_evt = 1'b0;
        tout_evt = 1'b0;
        if (sw_rst_req) begin
            nxt = ST_PLL_RST;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (rst_cnt == RST_LAST) nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s && (filt_cnt == FILT_LAST)) begin
                        nxt = ST_HOLD;
                    end else if (tout_cnt == TOUT_LAST) begin
                        nxt      = ST_PLL_RST;
                        tout_evt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!locked_s) begin
                        nxt      = ST_PLL_RST;
                        loss_evt = 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        nxt      = ST_PLL_RST;
                        loss_evt = 1'b1;
                    end
                end
                default: nxt = ST_PLL_RST;
            endcase
        end
    end

    // Any state change, or a software request that re-enters PLL_RST, starts the phase afresh.
    assign restart = sw_rst_req || (nxt != state);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= ST_PLL_RST;
            rst_cnt       <= '0;
            filt_cnt      <= '0;
            tout_cnt      <= '0;
            hold_cnt      <= '0;
            lock_lost_cnt <= '0;
            retry_cnt     <= '0;
            pll_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
        end else begin
            state   <= nxt;
            pll_rst <= (nxt == ST_PLL_RST);
            sys_rst <= (nxt != ST_RUN);
            ready   <= (nxt == ST_RUN);

            if (restart) begin
                rst_cnt  <= '0;
                filt_cnt <= '0;
                tout_cnt <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_PLL_RST:   rst_cnt <= rst_cnt + RST_W'(1);
                    ST_WAIT_LOCK: begin
                        tout_cnt <= tout_cnt + TOUT_W'(1);
                        filt_cnt <= locked_s ? (filt_cnt + FILT_W'(1)) : '0;
                    end
                    ST_HOLD:      hold_cnt <= hold_cnt + HOLD_W'(1);
                    default:      ;
                endcase
            end

            if (loss_evt && (lock_lost_cnt != LOST_CNT_MAX)) begin
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
            if (tout_evt && (retry_cnt != RETRY_CNT_MAX)) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed timing scenarios plus random lock/reset traffic against a timestamp model.
module tb_pll_reset_seq;

    localparam int PRC  = 4;
    localparam int FILT = 8;
    localparam int TOUT = 64;
    localparam int HOLD = 16;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic [3:0] retry_cnt;

    pll_reset_seq #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILT      (FILT),
        .LOCK_TIMEOUT   (TOUT),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_rst_req    (sw_rst_req),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt),
        .retry_cnt     (retry_cnt)
    );

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mode     = 0;

    // Reference model: phase plus edge timestamps; durations are differences of edge numbers.
    int m_phase    = P_RST;
    int m_edge     = 0;
    int m_entered  = 0;
    int m_last_low = 0;
    int m_lost     = 0;
    int m_retry    = 0;
    int m_s1       = 0;
    int m_s2       = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic enter(input int p);
        m_phase    = p;
        m_entered  = m_edge;
        m_last_low = m_edge;
    endtask

    task automatic model_edge();
        int ls;
        m_edge++;
        ls = m_s2;
        if (rst) begin
            enter(P_RST);
            m_lost  = 0;
            m_retry = 0;
            m_s1    = 0;
            m_s2    = 0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = pll_locked ? 1 : 0;
        if (sw_rst_req) begin
            enter(P_RST);
        end else if (m_phase == P_RST) begin
            if (m_edge - m_entered >= PRC) enter(P_WAIT);
        end else if (m_phase == P_WAIT) begin
            if (ls == 0) m_last_low = m_edge;
            if (ls == 1 && (m_edge - m_last_low) >= FILT) begin
                enter(P_HOLD);
            end else if (m_edge - m_entered >= TOUT) begin
                enter(P_RST);
                m_retry = imin(m_retry + 1, 15);
            end
        end else if (ls == 0) begin
            enter(P_RST);
            m_lost = imin(m_lost + 1, 255);
        end else if (m_phase == P_HOLD && (m_edge - m_entered >= HOLD)) begin
            enter(P_RUN);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        cyc++;
        check("pll_rst", pll_rst, m_phase == P_RST);
        check("sys_rst", sys_rst, m_phase != P_RUN);
        check("ready", ready, m_phase == P_RUN);
        check("lock_lost_cnt", lock_lost_cnt, m_lost);
        check("retry_cnt", retry_cnt, m_retry);
        check("sys_rst_covers_pll_rst", sys_rst || !pll_rst, 1);
        if (mode == 1 && cyc <= 40) begin
            check("s1_pll_rst_window", pll_rst, cyc < PRC);
            check("s1_ready_time", ready, cyc >= PRC + FILT + HOLD);
            check("s1_counters", lock_lost_cnt + retry_cnt, 0);
        end
        if (mode == 2) begin
            check("s2_pll_rst_period", pll_rst, (cyc % (PRC + TOUT)) < PRC);
            check("s2_retry_count", retry_cnt, imin(cyc / (PRC + TOUT), 15));
            check("s2_never_ready", ready, 0);
        end
    endtask

    task automatic run_to(input int n);
        for (int i = 0; i < 20000 && cyc < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        sw_rst_req = 1'b0;
        repeat (n) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    int outage;
    int r;

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
        outage     = 0;

        // Clean power-up with a locked PLL, then a one-cycle lock drop in RUN.
        do_reset(3);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_ready", ready, 0);
        mode = 1;
        run_to(40);
        mode = 0;
        check("run_reached", ready, 1);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        check("loss_ready_still_high", ready, 1);
        step();
        check("loss_ready_fall", ready, 0);
        check("loss_pll_rst", pll_rst, 1);
        check("loss_counted", lock_lost_cnt, 1);
        run_to(46);
        check("loss_pll_rst_last", pll_rst, 1);
        run_to(47);
        check("loss_pll_rst_end", pll_rst, 0);
        run_to(70);
        check("recover_not_yet", ready, 0);
        run_to(71);
        check("recover_ready", ready, 1);

        // Software request coinciding with the synchronized lock drop; then rst during HOLD.
        run_to(80);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check("sw_loss_pll_rst", pll_rst, 1);
        check("sw_loss_not_counted", lock_lost_cnt, 1);
        run_to(100);
        check("hold_sys_rst", sys_rst, 1);
        check("hold_pll_rst", pll_rst, 0);
        rst = 1'b1;
        step();
        check("mid_rst_pll_rst", pll_rst, 1);
        check("mid_rst_sys_rst", sys_rst, 1);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_lost", lock_lost_cnt, 0);

        // Lock glitch during WAIT_LOCK restarts only the filter.
        pll_locked = 1'b0;
        do_reset(2);
        run_to(PRC);
        pll_locked = 1'b1;
        run_to(11);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        run_to(37);
        check("glitch_not_ready", ready, 0);
        check("glitch_no_pll_rst", pll_rst, 0);
        step();
        check("glitch_ready", ready, 1);
        check("glitch_no_retry", retry_cnt, 0);

        // Never locking: periodic retries saturating at 15, kept after success.
        pll_locked = 1'b0;
        do_reset(2);
        mode = 2;
        run_to(17 * (PRC + TOUT) + 10);
        mode = 0;
        check("retry_saturated", retry_cnt, 15);
        pll_locked = 1'b1;
        run_to(cyc + 100);
        check("retry_kept_ready", ready, 1);
        check("retry_kept_value", retry_cnt, 15);

        // Random lock behaviour, software requests and resets.
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (outage > 0) begin
                pll_locked = 1'b0;
                outage--;
            end else if (pll_locked) begin
                pll_locked = (r < 20) ? 1'b0 : 1'b1;
            end else begin
                pll_locked = (r < 100) ? 1'b1 : 1'b0;
            end
            if ($urandom_range(0, 999) < 2) outage = $urandom_range(60, 150);
            sw_rst_req = ($urandom_range(0, 999) < 8) ? 1'b1 : 1'b0;
            rst        = ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
